exp_sigmoid_div: RTL and testbench

Sequential downstream stage for the exponential unit. It accepts the unit's Q32.32 product `e^x` over a valid/ready handshake and narrows it to Q16.16, saturating on overflow. It then computes `sigmoid(x) = e^x / (1 + e^x)` as an unsigned Q0.16 fraction using a 16-iteration restoring divider, one quotient bit per clock. The result is returned over a second valid/ready handshake.

---
 rtl/exp_sigmoid_div_if.sv | 21 ++
 rtl/exp_sigmoid_div.sv | 108 ++++++++++
 tb/tb_exp_sigmoid_div.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/exp_sigmoid_div_if.sv
// Handshake bundle between the exponential stage, the sigmoid divider and its consumer.
// The master side feeds operands and takes results; the slave side is the divider.
interface exp_sigmoid_div_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] exp_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sig_out;
    logic        sat;

    modport master (
        output in_valid, exp_in, out_ready,
        input  in_ready, out_valid, sig_out, sat
    );

    modport slave (
        input  in_valid, exp_in, out_ready,
        output in_ready, out_valid, sig_out, sat
    );
endinterface

// File: rtl/exp_sigmoid_div.sv
// Narrows a Q32.32 e^x to Q16.16 (saturating) and computes e/(1+e) as Q0.16
// with a 16-step restoring divider, one quotient bit per clock.
module exp_sigmoid_div (
    input logic               clk,
    input logic               rst,
    exp_sigmoid_div_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [32:0] ONE_Q16 = 33'h0_0001_0000;

    // Returns {sat, e}: the Q16.16 value, clamped to all-ones when the integer part overflows.
    function automatic logic [32:0] narrow_sat(input logic [47:0] hi);
        logic [32:0] res;
        if (hi[47:32] != 16'h0000)
            res = {1'b1, 32'hFFFF_FFFF};
        else
            res = {1'b0, hi[31:0]};
        return res;
    endfunction

    logic [1:0]  state;
    logic [33:0] r;
    logic [32:0] d;
    logic [15:0] q;
    logic [4:0]  cnt;
    logic        sat_r;
    logic [15:0] sig_q;
    logic        sat_q;

    logic [32:0] narrow_w;
    logic [31:0] e_w;
    logic        sat_w;
    logic [32:0] d_w;
    logic [33:0] r2;
    logic        ge;
    logic [33:0] r_next;
    logic [15:0] q_next;
    logic        frac_unused;

    // Fraction bits below Q16.16 are truncated by design.
    assign frac_unused = ^bus.exp_in[15:0];

    always_comb begin
        narrow_w = narrow_sat(bus.exp_in[63:16]);
        e_w      = narrow_w[31:0];
        sat_w    = narrow_w[32];
        d_w      = {1'b0, e_w} + ONE_Q16;
    end

    // One restoring-division step: remainder stays below d, so r2 fits in 34 bits.
    always_comb begin
        r2     = {r[32:0], 1'b0};
        ge     = (r2 >= {1'b0, d});
        r_next = ge ? (r2 - {1'b0, d}) : r2;
        q_next = {q[14:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            r     <= '0;
            d     <= '0;
            q     <= '0;
            cnt   <= '0;
            sat_r <= 1'b0;
            sig_q <= '0;
            sat_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r     <= {2'b00, e_w};
                        d     <= d_w;
                        q     <= '0;
                        cnt   <= '0;
                        sat_r <= sat_w;
                        state <= DIV;
                    end
                end
                DIV: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd15) begin
                        sig_q <= q_next;
                        sat_q <= sat_r;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sig_out   = sig_q;
    assign bus.sat       = sat_q;

endmodule

// File: tb/tb_exp_sigmoid_div.sv
// Directed bench for exp_sigmoid_div: reset, quotient values, saturation,
// backpressure, mid-operation reset and back-to-back initiation interval.
module tb_exp_sigmoid_div;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   acc_cyc = 0;
    int   prev_acc = 0;
    int   lat = 0;
    logic seen;

    exp_sigmoid_div_if bus ();

    exp_sigmoid_div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] ref_sig(input logic [63:0] x);
        logic [63:0] e;
        e = (x[63:48] != 16'h0) ? 64'h0000_0000_FFFF_FFFF : {32'h0, x[47:16]};
        return 16'((e << 16) / (e + 64'h1_0000));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Waits (bounded) for in_ready at the current negedge, then takes the accept edge.
    task automatic accept_now();
        int g;
        g = 0;
        while (!bus.in_ready && g < 60) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
    endtask

    task automatic wait_out();
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        lat = seen ? (cyc - acc_cyc) : 999;
    endtask

    task automatic run_op(input string tag, input logic [63:0] x,
                          input logic [15:0] esig, input logic esat);
        @(negedge clk);
        bus.exp_in   = x;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        accept_now();
        bus.in_valid = 1'b0;
        wait_out();
        chk({tag, "_lat"}, lat, 16);
        chk({tag, "_sig"}, {16'h0, bus.sig_out}, {16'h0, esig});
        chk({tag, "_sat"}, {31'h0, bus.sat}, {31'h0, esat});
        @(posedge clk);
        #1;
        chk({tag, "_release"}, {31'h0, bus.out_valid}, 32'h0);
    endtask

    logic [63:0] ops [4];

    initial begin
        bus.in_valid  = 1'b0;
        bus.exp_in    = '0;
        bus.out_ready = 1'b0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'h0, bus.in_ready},  32'h1);
        chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("rst_sig",       {16'h0, bus.sig_out},   32'h0);
        chk("rst_sat",       {31'h0, bus.sat},       32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_op("one",   64'h0000_0001_0000_0000, 16'h8000, 1'b0);
        run_op("zero",  64'h0000_0000_0000_0000, 16'h0000, 1'b0);
        run_op("three", 64'h0000_0003_0000_0000, 16'hC000, 1'b0);
        run_op("half",  64'h0000_0000_8000_0000, 16'h5555, 1'b0);
        run_op("satur", 64'h0001_0000_0000_0000, 16'hFFFF, 1'b1);
        run_op("unsat", 64'h0000_0001_0000_0000, 16'h8000, 1'b0);
        run_op("maxq",  64'h0000_FFFF_FFFF_FFFF, 16'hFFFF, 1'b0);

        // Backpressure: result held while out_ready is low, new operands ignored.
        @(negedge clk);
        bus.exp_in    = 64'h0000_0001_0000_0000;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        accept_now();
        bus.in_valid = 1'b0;
        wait_out();
        chk("bp_lat", lat, 16);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = ~bus.in_valid;
            bus.exp_in   = 64'h0000_0003_0000_0000 + 64'(i);
            @(posedge clk);
            #1;
            chk("bp_out_valid", {31'h0, bus.out_valid}, 32'h1);
            chk("bp_sig",       {16'h0, bus.sig_out},   32'h8000);
            chk("bp_in_ready",  {31'h0, bus.in_ready},  32'h0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.exp_in    = 64'h0000_0003_0000_0000;
        @(posedge clk);
        #1;
        chk("bp_retired",  {31'h0, bus.out_valid}, 32'h0);
        chk("bp_idle",     {31'h0, bus.in_ready},  32'h1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        chk("bp_accepted", {31'h0, bus.in_ready},  32'h0);
        bus.in_valid = 1'b0;
        wait_out();
        chk("bp2_lat", lat, 16);
        chk("bp2_sig", {16'h0, bus.sig_out}, 32'hC000);
        @(posedge clk);
        #1;

        // Reset during DIV discards the operation.
        @(negedge clk);
        bus.exp_in   = 64'h0000_0001_0000_0000;
        bus.in_valid = 1'b1;
        accept_now();
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_in_ready",  {31'h0, bus.in_ready},  32'h1);
        chk("mid_rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("mid_rst_sig",       {16'h0, bus.sig_out},   32'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("mid_rst_no_result", {31'h0, seen}, 32'h0);
        run_op("after_rst", 64'h0000_0003_0000_0000, 16'hC000, 1'b0);

        // Back-to-back: in_valid and out_ready held high.
        ops[0] = 64'h0000_0002_0000_0000;
        ops[1] = 64'h0000_0007_0000_0000;
        ops[2] = 64'h0000_0000_4000_0000;
        ops[3] = 64'h0000_0000_0001_0000;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.exp_in    = ops[0];
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            accept_now();
            if (k > 0) chk("b2b_interval", acc_cyc - prev_acc, 18);
            prev_acc = acc_cyc;
            wait_out();
            chk("b2b_lat", lat, 16);
            chk("b2b_sig", {16'h0, bus.sig_out}, {16'h0, ref_sig(ops[k])});
            if (k < 3) bus.exp_in = ops[k + 1];
        end
        bus.in_valid = 1'b0;
        chk("b2b_const_2", {16'h0, ref_sig(ops[0])}, 32'hAAAA);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
